// File: rtl/mem_ctrl_line.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : mem_ctrl_line
//  Purpose  : Byte-serial RAM controller shared by an icache line-refill port
//             and the load/store buffer port. Reads are pipelined (address
//             issue overlaps data capture), arbitration is rotating-priority,
//             and a flush aborts an in-flight instruction fetch.
//  Ports    : clk, rst (sync, active-high), rdy (global enable), flush
//             ifetch_req/addr -> ifetch_valid/data   (whole line)
//             lsb_req/we/addr/size/signed/wdata -> lsb_valid/rdata
//             ram_we/addr/dout -> RAM, ram_din <- RAM (one-cycle latency)
//  Revision : 1.0 - initial parametrised line-refill version
// ============================================================================
module mem_ctrl_line #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      ifetch_req,
    input  logic [ADDR_W-1:0]         ifetch_addr,
    output logic                      ifetch_valid,
    output logic [8*LINE_BYTES-1:0]   ifetch_data,
    input  logic                      lsb_req,
    input  logic                      lsb_we,
    input  logic [ADDR_W-1:0]         lsb_addr,
    input  logic [1:0]                lsb_size,
    input  logic                      lsb_signed,
    input  logic [31:0]               lsb_wdata,
    output logic                      lsb_valid,
    output logic [31:0]               lsb_rdata,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [7:0]                ram_dout,
    input  logic [7:0]                ram_din
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int CNT_W  = OFF_W + 1;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam logic [CNT_W-1:0]  LINE_CNT  = CNT_W'(LINE_BYTES);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q,        state_d;
    logic                prio_q,         prio_d;      // 0 = favour LSB, 1 = favour fetch
    logic                fetch_q,        fetch_d;     // current transaction is a fetch
    logic [ADDR_W-1:0]   ram_addr_q,     ram_addr_d;
    logic                ram_we_q,       ram_we_d;
    logic [7:0]          ram_dout_q,     ram_dout_d;
    logic [23:0]         wdata_q,        wdata_d;     // store bytes not yet issued
    logic [1:0]          size_q,         size_d;
    logic                signed_q,       signed_d;
    logic [CNT_W-1:0]    n_q,            n_d;         // bytes in this transaction
    logic [CNT_W-1:0]    iss_q,          iss_d;       // addresses / bytes still to issue
    logic [CNT_W-1:0]    cap_q,          cap_d;       // read bytes still to capture
    logic                warm_q,         warm_d;      // first READ edge: RAM data not yet valid
    logic [LINE_W-1:0]   buf_q,          buf_d;       // assembly buffer for read bytes
    logic                ifetch_valid_q, ifetch_valid_d;
    logic [LINE_W-1:0]   ifetch_data_q,  ifetch_data_d;
    logic                lsb_valid_q,    lsb_valid_d;
    logic [31:0]         lsb_rdata_q,    lsb_rdata_d;

    logic                w_take_fetch;
    logic                w_take_lsb;
    logic [CNT_W-1:0]    w_lsb_n;
    logic [CNT_W-1:0]    w_cap_idx;

    function automatic logic [CNT_W-1:0] size_to_n(input logic [1:0] s);
        case (s)
            2'd0:    return CNT_W'(1);
            2'd1:    return CNT_W'(2);
            default: return CNT_W'(4);
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] s,
                                           input logic sg);
        case (s)
            2'd0:    return {{24{sg & w[7]}}, w[7:0]};
            2'd1:    return {{16{sg & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    // A fetch only wins when it may be accepted at all (no flush this cycle);
    // with both ports eligible, prio_q breaks the tie.
    assign w_take_fetch = ifetch_req & ~flush & (~lsb_req | prio_q);
    assign w_take_lsb   = lsb_req & ~w_take_fetch;
    assign w_lsb_n      = size_to_n(lsb_size);
    assign w_cap_idx    = n_q - cap_q;

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        fetch_d        = fetch_q;
        ram_addr_d     = ram_addr_q;
        ram_we_d       = ram_we_q;
        ram_dout_d     = ram_dout_q;
        wdata_d        = wdata_q;
        size_d         = size_q;
        signed_d       = signed_q;
        n_d            = n_q;
        iss_d          = iss_q;
        cap_d          = cap_q;
        warm_d         = warm_q;
        buf_d          = buf_q;
        ifetch_valid_d = 1'b0;
        ifetch_data_d  = ifetch_data_q;
        lsb_valid_d    = 1'b0;
        lsb_rdata_d    = lsb_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_take_fetch) begin
                    fetch_d    = 1'b1;
                    prio_d     = 1'b0;
                    ram_addr_d = ifetch_addr & LINE_MASK;
                    n_d        = LINE_CNT;
                    iss_d      = LINE_CNT - CNT_W'(1);
                    cap_d      = LINE_CNT;
                    warm_d     = 1'b1;
                    state_d    = S_READ;
                end else if (w_take_lsb) begin
                    fetch_d    = 1'b0;
                    prio_d     = 1'b1;
                    ram_addr_d = lsb_addr;
                    size_d     = lsb_size;
                    signed_d   = lsb_signed;
                    n_d        = w_lsb_n;
                    iss_d      = w_lsb_n - CNT_W'(1);
                    if (lsb_we) begin
                        ram_we_d   = 1'b1;
                        ram_dout_d = lsb_wdata[7:0];
                        wdata_d    = lsb_wdata[31:8];
                        state_d    = S_WRITE;
                    end else begin
                        cap_d   = w_lsb_n;
                        warm_d  = 1'b1;
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                if (fetch_q && flush) begin
                    // Partial line is dropped; buf_q is scratch so the
                    // visible ifetch_data keeps the previous line.
                    ram_addr_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    if (iss_q != '0) begin
                        ram_addr_d = ram_addr_q + ADDR_W'(1);
                        iss_d      = iss_q - CNT_W'(1);
                    end
                    if (warm_q) begin
                        warm_d = 1'b0;
                    end else begin
                        for (int k = 0; k < LINE_BYTES; k++) begin
                            if (w_cap_idx == CNT_W'(k)) begin
                                buf_d[8*k +: 8] = ram_din;
                            end
                        end
                        cap_d = cap_q - CNT_W'(1);
                        if (cap_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                            if (fetch_q) begin
                                ifetch_valid_d = 1'b1;
                                ifetch_data_d  = buf_d;
                            end else begin
                                lsb_valid_d = 1'b1;
                                lsb_rdata_d = extend(buf_d[31:0], size_q, signed_q);
                            end
                        end
                    end
                end
            end

            S_WRITE: begin
                if (iss_q != '0) begin
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_dout_d = wdata_q[7:0];
                    wdata_d    = {8'h00, wdata_q[23:8]};
                    iss_d      = iss_q - CNT_W'(1);
                end else begin
                    ram_we_d    = 1'b0;
                    lsb_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                // One dead cycle so the requester can drop its request.
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            prio_q         <= 1'b0;
            fetch_q        <= 1'b0;
            ram_addr_q     <= '0;
            ram_we_q       <= 1'b0;
            ram_dout_q     <= '0;
            wdata_q        <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            n_q            <= '0;
            iss_q          <= '0;
            cap_q          <= '0;
            warm_q         <= 1'b0;
            buf_q          <= '0;
            ifetch_valid_q <= 1'b0;
            ifetch_data_q  <= '0;
            lsb_valid_q    <= 1'b0;
            lsb_rdata_q    <= '0;
        end else if (rdy) begin
            state_q        <= state_d;
            prio_q         <= prio_d;
            fetch_q        <= fetch_d;
            ram_addr_q     <= ram_addr_d;
            ram_we_q       <= ram_we_d;
            ram_dout_q     <= ram_dout_d;
            wdata_q        <= wdata_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            n_q            <= n_d;
            iss_q          <= iss_d;
            cap_q          <= cap_d;
            warm_q         <= warm_d;
            buf_q          <= buf_d;
            ifetch_valid_q <= ifetch_valid_d;
            ifetch_data_q  <= ifetch_data_d;
            lsb_valid_q    <= lsb_valid_d;
            lsb_rdata_q    <= lsb_rdata_d;
        end
    end

    assign ifetch_valid = ifetch_valid_q;
    assign ifetch_data  = ifetch_data_q;
    assign lsb_valid    = lsb_valid_q;
    assign lsb_rdata    = lsb_rdata_q;
    assign ram_we       = ram_we_q & rdy;   // never write while the system is stalled
    assign ram_addr     = ram_addr_q;
    assign ram_dout     = ram_dout_q;

endmodule
`default_nettype wire
